// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared definitions for the load/store master: access-mode codes,
//            FSM state encoding and a mode-legality helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Access-mode codes presented on op_mode
  localparam logic [3:0] MODE_W  = 4'd0;  // word
  localparam logic [3:0] MODE_B  = 4'd1;  // byte, sign-extended
  localparam logic [3:0] MODE_H  = 4'd2;  // half, sign-extended
  localparam logic [3:0] MODE_BU = 4'd3;  // byte, zero-extended
  localparam logic [3:0] MODE_HU = 4'd4;  // half, zero-extended

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Stores only know word/byte/half; loads additionally have the unsigned forms.
  function automatic logic mode_legal(input logic write, input logic [3:0] mode);
    if (write) begin
      return (mode == MODE_W) || (mode == MODE_B) || (mode == MODE_H);
    end
    return (mode <= MODE_HU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_ext.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ext
// Purpose  : Load-data lane selection and sign/zero extension (combinational).
// Ports    : word [31:0]  - raw read word from memory
//            mode [3:0]   - access mode (lsu_pkg MODE_*)
//            addr [1:0]   - low byte-address bits of the access
//            data [31:0]  - extended load result (0 for unknown modes)
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ext
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [3:0]  mode,
  input  logic [1:0]  addr,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase

    // addr[0] is deliberately ignored for halves: a misaligned half reads the
    // half that contains it.
    half_sel = addr[1] ? word[31:16] : word[15:0];

    case (mode)
      MODE_W:  data = word;
      MODE_B:  data = {{24{byte_sel[7]}}, byte_sel};
      MODE_H:  data = {{16{half_sel[15]}}, half_sel};
      MODE_BU: data = {24'h0, byte_sel};
      MODE_HU: data = {16'h0, half_sel};
      default: data = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_master
// Purpose  : Single-outstanding load/store unit. Captures one pipeline memory
//            op, issues one lane-aligned memory request, waits for mem_ack and
//            returns the extended load data for one cycle.
// Ports    : clk, reset (async, active high)
//            op_valid/op_write/op_mode/op_addr/op_wdata/op_pc - pipeline op
//            stall                  - hold the pipeline
//            ld_valid/ld_data/exc   - completion (valid in DONE only)
//            mem_req/mem_we/mem_be/mem_addr/mem_wdata - memory request
//            mem_ack/mem_rdata      - memory response
// Config   : define LSU_ADDR_EXC_EN to enable alignment / range exceptions
//            (addresses above ADDR_LIMIT raise exc instead of being issued).
// Revision : 1.0 - initial release
// ============================================================================
module lsu_master
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_2FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_write,
  input  logic [3:0]  op_mode,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [31:0] op_pc,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        exc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  state_e      state_q,    state_d;
  logic        write_q,    write_d;
  logic [3:0]  mode_q,     mode_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [31:0] pc_q,       pc_d;      // held with the op for exception reporting
  logic        ld_valid_q, ld_valid_d;
  logic        exc_q,      exc_d;
  logic [31:0] ld_data_q,  ld_data_d;

  logic        mode_ok;
  logic        addr_exc;
  logic [31:0] ext_data;
  logic [3:0]  be_calc;
  logic [31:0] wdata_rep;

  lsu_ext u_ext (
    .word (mem_rdata),
    .mode (mode_q),
    .addr (addr_q[1:0]),
    .data (ext_data)
  );

  // Legality is judged on the incoming op so a bad op never reaches REQ.
  always_comb begin
    mode_ok = mode_legal(op_write, op_mode);
`ifdef LSU_ADDR_EXC_EN
    addr_exc = 1'b0;
    if (mode_ok) begin
      if (op_addr > ADDR_LIMIT) addr_exc = 1'b1;
      if (((op_mode == MODE_H) || (op_mode == MODE_HU)) && op_addr[0]) addr_exc = 1'b1;
      if ((op_mode == MODE_W) && (op_addr[1:0] != 2'b00)) addr_exc = 1'b1;
    end
`else
    addr_exc = 1'b0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    pc_d       = pc_q;
    ld_valid_d = 1'b0;
    exc_d      = 1'b0;
    ld_data_d  = ld_data_q;

    case (state_q)
      IDLE: begin
        if (op_valid) begin
          write_d = op_write;
          mode_d  = op_mode;
          addr_d  = op_addr;
          wdata_d = op_wdata;
          pc_d    = op_pc;
          if (!mode_ok || addr_exc) begin
            // Skipped op completes without touching memory.
            state_d    = DONE;
            ld_valid_d = !op_write && !addr_exc;
            exc_d      = addr_exc;
            ld_data_d  = 32'h0;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d    = DONE;
          ld_valid_d = !write_q;
          if (!write_q) ld_data_d = ext_data;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      mode_q     <= 4'h0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      pc_q       <= 32'h0;
      ld_valid_q <= 1'b0;
      exc_q      <= 1'b0;
      ld_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      pc_q       <= pc_d;
      ld_valid_q <= ld_valid_d;
      exc_q      <= exc_d;
      ld_data_q  <= ld_data_d;
    end
  end

  // Byte enables and lane replication from the captured op.
  always_comb begin
    be_calc   = 4'hF;
    wdata_rep = wdata_q;
    if (write_q) begin
      case (mode_q)
        MODE_B: begin
          be_calc   = 4'b0001 << addr_q[1:0];
          wdata_rep = {4{wdata_q[7:0]}};
        end
        MODE_H: begin
          be_calc   = addr_q[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{wdata_q[15:0]}};
        end
        default: begin
          be_calc   = 4'hF;
          wdata_rep = wdata_q;
        end
      endcase
    end
  end

  // Memory outputs derive only from flops, so they are stable through REQ and
  // drop the instant reset forces the state back to IDLE.
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req && write_q;
  assign mem_be    = mem_req ? be_calc : 4'h0;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_rep;

  assign stall     = op_valid && (state_q != DONE);
  assign ld_valid  = ld_valid_q;
  assign exc       = exc_q;
  assign ld_data   = ld_data_q;

endmodule
`default_nettype wire
